// File: rtl/sprite_fetch.sv
// Sprite fetch stage: maps the raster position onto a 16x16 sprite, addresses the
// sprite ROM, animates four frames ping-pong and registers the returned pixel.
module sprite_fetch #(
  parameter int unsigned ANIM_DIV    = 8,
  parameter logic [3:0]  TRANSPARENT = 4'h0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       frame_tick,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       anim_en,
  output logic [9:0] rom_add,
  input  logic [3:0] rom_pixel,
  output logic [1:0] frame_idx,
  output logic       pix_valid,
  output logic [3:0] pix_color
);

  localparam logic [0:0] ST_UP   = 1'b0;
  localparam logic [0:0] ST_DOWN = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(ANIM_DIV - 1);

  logic [9:0] sx_q, sx_d;
  logic [9:0] sy_q, sy_d;
  logic [7:0] cnt_q, cnt_d;
  logic [0:0] dir_q, dir_d;
  logic [1:0] frame_q, frame_d;
  logic [9:0] rom_add_q, rom_add_d;
  logic       hit1_q, hit1_d;
  logic       hit2_q, hit2_d;
  logic       pix_valid_q, pix_valid_d;
  logic [3:0] pix_color_q, pix_color_d;

  logic [9:0] dx;
  logic [9:0] dy;
  logic       hit;

  // Position and animation state only move on frame_tick so a frame never tears.
  always_comb begin
    sx_d    = sx_q;
    sy_d    = sy_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    frame_d = frame_q;
    if (frame_tick) begin
      sx_d = pos_x;
      sy_d = pos_y;
    end
    if (frame_tick && anim_en) begin
      if (cnt_q != CNT_LAST) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        cnt_d = '0;
        if (dir_q == ST_UP) begin
          if (frame_q != 2'd3) begin
            frame_d = frame_q + 2'd1;
          end else begin
            dir_d   = ST_DOWN;
            frame_d = 2'd2;
          end
        end else begin
          if (frame_q != 2'd0) begin
            frame_d = frame_q - 2'd1;
          end else begin
            dir_d   = ST_UP;
            frame_d = 2'd1;
          end
        end
      end
    end
  end

  // Unsigned wrap in dx/dy lets a sprite near column 1023 continue at column 0.
  always_comb begin
    dx          = x - sx_q;
    dy          = y - sy_q;
    hit         = (dx < 10'd16) && (dy < 10'd16);
    rom_add_d   = {frame_q, dy[3:0], dx[3:0]};
    hit1_d      = hit;
    hit2_d      = hit1_q;
    pix_valid_d = hit2_q && (rom_pixel != TRANSPARENT);
    pix_color_d = pix_valid_d ? rom_pixel : 4'h0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sx_q        <= '0;
      sy_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= ST_UP;
      frame_q     <= '0;
      rom_add_q   <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_color_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      frame_q     <= frame_d;
      rom_add_q   <= rom_add_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      pix_valid_q <= pix_valid_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign rom_add   = rom_add_q;
  assign frame_idx = frame_q;
  assign pix_valid = pix_valid_q;
  assign pix_color = pix_color_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed bench for sprite_fetch with a registered-read sprite ROM model.
module tb_sprite_fetch;

  localparam logic [9:0] IDLE = 10'd1023;

  logic       clk = 1'b0;
  logic       rstn;
  logic [9:0] x, y, pos_x, pos_y;
  logic       frame_tick, anim_en;
  logic [9:0] rom_add;
  logic [3:0] rom_pixel;
  logic [1:0] frame_idx;
  logic       pix_valid;
  logic [3:0] pix_color;

  logic [3:0] rom [1024];
  logic [9:0] seen_add;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned seq_exp [7] = '{1, 2, 3, 2, 1, 0, 1};

  sprite_fetch #(.ANIM_DIV(2), .TRANSPARENT(4'h0)) dut (
    .clk(clk), .rstn(rstn), .x(x), .y(y), .frame_tick(frame_tick),
    .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en), .rom_add(rom_add),
    .rom_pixel(rom_pixel), .frame_idx(frame_idx), .pix_valid(pix_valid),
    .pix_color(pix_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_pixel <= rom[rom_add];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (3) step();
  endtask

  // Drive one raster position for a cycle; returns when its pixel is at the outputs.
  task automatic present(input logic [9:0] xv, input logic [9:0] yv);
    x = xv;
    y = yv;
    step();
    seen_add = rom_add;
    x = IDLE;
    y = IDLE;
    repeat (2) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0; frame_tick = 1'b1; anim_en = 1'b1;
    x = 10'd102; y = 10'd52; pos_x = 10'd100; pos_y = 10'd50;
    repeat (2) step();
    vectors++;
    if ({rom_add, frame_idx, pix_valid, pix_color} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got add=%h frm=%0d v=%b c=%h, expected all 0",
               rom_add, frame_idx, pix_valid, pix_color);
    end
    rstn = 1'b1; frame_tick = 1'b0; x = IDLE; y = IDLE;
    repeat (3) step();
    tick();
    vectors++;
    if (frame_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_frame_hold: got %0d expected 0", frame_idx);
    end
    tick();
    vectors++;
    if (frame_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL reset_first_step: got %0d expected 1", frame_idx);
    end
  endtask

  task automatic test_latency();
    anim_en = 1'b0;
    do_reset();
    pos_x = 10'd100; pos_y = 10'd50;
    tick();
    x = 10'd102; y = 10'd52;
    step();
    vectors++;
    if (rom_add !== 10'h022) begin
      miscompares++;
      $display("FAIL lat_rom_add: got %h expected 022", rom_add);
    end
    x = IDLE; y = IDLE;
    step();
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_early: got valid=%b expected 0 at 2 clk", pix_valid);
    end
    step();
    vectors++;
    if (pix_valid !== 1'b1 || pix_color !== 4'h5) begin
      miscompares++;
      $display("FAIL lat_hit: got v=%b c=%h expected v=1 c=5", pix_valid, pix_color);
    end
    step();
    vectors++;
    if (pix_valid !== 1'b0 || pix_color !== 4'h0) begin
      miscompares++;
      $display("FAIL lat_after: got v=%b c=%h expected v=0 c=0", pix_valid, pix_color);
    end
  endtask

  task automatic test_transparency();
    present(10'd99, 10'd52);
    vectors++;
    if (pix_valid !== 1'b0 || pix_color !== 4'h0) begin
      miscompares++;
      $display("FAIL miss_left: got v=%b c=%h expected v=0 c=0", pix_valid, pix_color);
    end
    present(10'd115, 10'd65);
    vectors++;
    if (seen_add !== 10'h0FF || pix_valid !== 1'b0 || pix_color !== 4'h0) begin
      miscompares++;
      $display("FAIL transparent: got add=%h v=%b c=%h expected add=0ff v=0 c=0",
               seen_add, pix_valid, pix_color);
    end
  endtask

  task automatic test_tear_free();
    pos_x = 10'd200;
    present(10'd102, 10'd52);
    vectors++;
    if (pix_valid !== 1'b1 || pix_color !== 4'h5) begin
      miscompares++;
      $display("FAIL tear_old_hit: got v=%b c=%h expected v=1 c=5", pix_valid, pix_color);
    end
    present(10'd202, 10'd52);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tear_new_early: got v=%b expected 0", pix_valid);
    end
    tick();
    present(10'd202, 10'd52);
    vectors++;
    if (seen_add !== 10'h022 || pix_valid !== 1'b1 || pix_color !== 4'h5) begin
      miscompares++;
      $display("FAIL tear_new_hit: got add=%h v=%b c=%h expected add=022 v=1 c=5",
               seen_add, pix_valid, pix_color);
    end
    present(10'd102, 10'd52);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL tear_old_gone: got v=%b expected 0", pix_valid);
    end
  endtask

  task automatic test_animation();
    anim_en = 1'b0;
    do_reset();
    anim_en = 1'b1;
    for (int unsigned i = 0; i < 7; i++) begin
      tick();
      tick();
      vectors++;
      if (frame_idx !== 2'(seq_exp[i])) begin
        miscompares++;
        $display("FAIL anim_seq[%0d]: got %0d expected %0d", i, frame_idx, seq_exp[i]);
      end
    end
    anim_en = 1'b0;
    repeat (4) tick();
    vectors++;
    if (frame_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL anim_freeze: got %0d expected 1", frame_idx);
    end
    anim_en = 1'b1;
    frame_tick = 1'b1;
    repeat (2) step();
    frame_tick = 1'b0;
    vectors++;
    if (frame_idx !== 2'd2) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d expected 2", frame_idx);
    end
    present(10'd202, 10'd52);
    vectors++;
    if (seen_add !== 10'h222 || pix_valid !== 1'b1 || pix_color !== 4'h7) begin
      miscompares++;
      $display("FAIL anim_frame2_pix: got add=%h v=%b c=%h expected add=222 v=1 c=7",
               seen_add, pix_valid, pix_color);
    end
    tick();
    x = 10'd202; y = 10'd52;
    tick();
    x = IDLE; y = IDLE;
    vectors++;
    if (rom_add !== 10'h222 || frame_idx !== 2'd3) begin
      miscompares++;
      $display("FAIL tick_with_hit: got add=%h frm=%0d expected add=222 frm=3",
               rom_add, frame_idx);
    end
    present(10'd202, 10'd52);
    vectors++;
    if (seen_add !== 10'h322) begin
      miscompares++;
      $display("FAIL tick_next_frame: got add=%h expected 322", seen_add);
    end
  endtask

  task automatic test_wrap_reset();
    anim_en = 1'b0;
    pos_x = 10'd1020; pos_y = 10'd50;
    tick();
    present(10'd2, 10'd52);
    vectors++;
    if (seen_add !== 10'h326 || pix_valid !== 1'b1 || pix_color !== 4'hC) begin
      miscompares++;
      $display("FAIL wrap_hit: got add=%h v=%b c=%h expected add=326 v=1 c=c",
               seen_add, pix_valid, pix_color);
    end
    present(10'd11, 10'd52);
    vectors++;
    if (seen_add !== 10'h32F || pix_valid !== 1'b1 || pix_color !== 4'h6) begin
      miscompares++;
      $display("FAIL wrap_right_edge: got add=%h v=%b c=%h expected add=32f v=1 c=6",
               seen_add, pix_valid, pix_color);
    end
    present(10'd12, 10'd52);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_past_edge: got v=%b expected 0", pix_valid);
    end
    present(10'd1019, 10'd52);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_before_left: got v=%b expected 0", pix_valid);
    end
    x = 10'd2; y = 10'd52;
    repeat (3) step();
    vectors++;
    if (pix_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_valid: got v=%b expected 1", pix_valid);
    end
    rstn = 1'b0;
    step();
    vectors++;
    if ({rom_add, frame_idx, pix_valid, pix_color} !== 17'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got add=%h frm=%0d v=%b c=%h expected all 0",
               rom_add, frame_idx, pix_valid, pix_color);
    end
    rstn = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (pix_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush[%0d]: got v=%b expected 0", i, pix_valid);
      end
    end
    x = IDLE; y = IDLE;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 4'((i % 15) + 1);
    rom[10'h0FF] = 4'h0;
    rstn = 1'b0; frame_tick = 1'b0; anim_en = 1'b0;
    x = IDLE; y = IDLE; pos_x = '0; pos_y = '0;
    step();
    test_reset();
    test_latency();
    test_transparency();
    test_tear_free();
    test_animation();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
